// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x oversampling UART receiver with majority-vote bit
// sampling, optional parity, stop-bit check and a Valid/Ack output holder.
module uart_rx_os16 #(
  parameter int TICK_DIV   = 326,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       DSin,
  input  logic       Ack,
  output logic [7:0] DPout,
  output logic       Valid,
  output logic       Reading,
  output logic       FrameErr,
  output logic       ParityErr,
  output logic       Overrun,
  output logic [2:0] dbg_state_o
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          ds_m_q, ds_s_q;
  logic [1:0]    fill_q, fill_d;
  logic          arm_q, arm_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    phase_q, phase_d;
  logic          s7_q, s7_d, s8_q, s8_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bit_q, par_bit_d;
  logic          reading_q, reading_d;
  logic          valid_q, valid_d;
  logic [7:0]    dpout_q, dpout_d;
  logic          ferr_q, ferr_d;
  logic          perr_q, perr_d;
  logic          ovr_q, ovr_d;

  logic tick, sample_pt, end_pt, maj, complete, perr_calc;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign sample_pt = tick && (phase_q == 4'd9);
  assign end_pt    = tick && (phase_q == 4'd15);
  // Majority of the phase 7, 8 and 9 samples; the phase 9 sample is live.
  assign maj       = (s7_q & s8_q) | (s7_q & ds_s_q) | (s8_q & ds_s_q);
  assign perr_calc = PARITY_EN ? (((^shift_q) ^ par_bit_q) != PARITY_ODD) : 1'b0;

  // Two-flop synchronizer for the asynchronous serial line, idle-high.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ds_m_q <= 1'b1;
      ds_s_q <= 1'b1;
    end else begin
      ds_m_q <= DSin;
      ds_s_q <= ds_m_q;
    end
  end

  // Next-state logic: FSM, bit timing, shift register and output holder.
  // Handshake: Valid rises when a byte is loaded and holds DPout and the
  // flags stable until an edge with Ack = 1 and Valid = 1; Ack while Valid = 0
  // has no effect. A completing frame on an acknowledging edge is loaded.
  always_comb begin
    state_d    = state_q;
    fill_d     = {fill_q[0], 1'b1};
    arm_d      = arm_q | (fill_q[1] & ds_s_q);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    phase_d    = tick ? phase_q + 4'd1 : phase_q;
    s7_d       = (tick && phase_q == 4'd7) ? ds_s_q : s7_q;
    s8_d       = (tick && phase_q == 4'd8) ? ds_s_q : s8_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    reading_d  = reading_q;
    valid_d    = valid_q;
    dpout_d    = dpout_q;
    ferr_d     = ferr_q;
    perr_d     = perr_q;
    ovr_d      = ovr_q;
    complete   = 1'b0;

    case (state_q)
      IDLE: begin
        phase_d   = 4'd0;
        bit_cnt_d = 3'd0;
        // A start is only accepted once the line has been seen high.
        if (arm_q && !ds_s_q) state_d = START;
        else                  tick_cnt_d = '0;
      end
      START: begin
        if (sample_pt) begin
          if (maj) state_d = IDLE;
          else     reading_d = 1'b1;
        end
        if (end_pt) state_d = DATA;
      end
      DATA: begin
        if (sample_pt) shift_d = {maj, shift_q[7:1]};
        if (end_pt) begin
          if (bit_cnt_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      PARITY: begin
        if (sample_pt) par_bit_d = maj;
        if (end_pt)    state_d = STOP;
      end
      STOP: begin
        if (sample_pt) begin
          complete  = 1'b1;
          reading_d = 1'b0;
          state_d   = maj ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        tick_cnt_d = '0;
        phase_d    = 4'd0;
        if (ds_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (Ack && valid_q) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      perr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
    if (complete) begin
      if (!valid_q || Ack) begin
        valid_d = 1'b1;
        dpout_d = shift_q;
        ferr_d  = !maj;
        perr_d  = perr_calc;
        ovr_d   = 1'b0;
      end else begin
        ovr_d   = 1'b1;
      end
    end
  end

  // State register for the FSM, counters and held outputs.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= IDLE;
      fill_q     <= 2'b00;
      arm_q      <= 1'b0;
      tick_cnt_q <= '0;
      phase_q    <= 4'd0;
      s7_q       <= 1'b0;
      s8_q       <= 1'b0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      par_bit_q  <= 1'b0;
      reading_q  <= 1'b0;
      valid_q    <= 1'b0;
      dpout_q    <= 8'd0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      arm_q      <= arm_d;
      tick_cnt_q <= tick_cnt_d;
      phase_q    <= phase_d;
      s7_q       <= s7_d;
      s8_q       <= s8_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      reading_q  <= reading_d;
      valid_q    <= valid_d;
      dpout_q    <= dpout_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign DPout       = dpout_q;
  assign Valid       = valid_q;
  assign Reading     = reading_q;
  assign FrameErr    = ferr_q;
  assign ParityErr   = perr_q;
  assign Overrun     = ovr_q;
  assign dbg_state_o = state_q;

endmodule
